// File: rtl/alu_pkg.sv
// Shared ALU definitions: control encodings used by the ALU decoder and the
// multiply sequencer, plus the multiply FSM state type.
package alu_pkg;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_XOR = 3'b001;
  localparam logic [2:0] ALU_SLL = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b011;
  localparam logic [2:0] ALU_MUL = 3'b100;
  localparam logic [2:0] ALU_ADD = 3'b101;
  localparam logic [2:0] ALU_SRA = 3'b110;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } mul_state_t;

endpackage

// File: rtl/mul_shift_add_dp.sv
// Shift-add multiply datapath: latches operands on load, performs one
// add/shift iteration per step, flags the final iteration with last.
module mul_shift_add_dp #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  output logic [WIDTH-1:0] acc,
  output logic             last
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else if (load) begin
      mcand  <= data1;
      mplier <= data2;
      acc    <= '0;
      cnt    <= '0;
    end else if (step) begin
      if (mplier[0]) begin
        acc <= acc + mcand;
      end
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
    end
  end

  assign last = (cnt == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/mul_sequencer.sv
// Multi-cycle MUL sequencer for the EX stage: stalls the pipeline while the
// shift-add datapath runs, then presents the low WIDTH product bits for one cycle.
module mul_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH    = 32,
  parameter logic [2:0]  CTRL_MUL = ALU_MUL
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  input  logic [2:0]       ALUCtrl_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  output logic             stall_o,
  output logic             done_o,
  output logic [WIDTH-1:0] data_o
);

  mul_state_t       state;
  logic             start;
  logic             load;
  logic             step;
  logic             last;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] result;

  assign start = valid_i && (ALUCtrl_i == CTRL_MUL) && !flush_i;
  assign load  = (state == IDLE) && start;
  assign step  = (state == BUSY);

  mul_shift_add_dp #(
    .WIDTH(WIDTH)
  ) u_dp (
    .clk   (clk_i),
    .rst   (rst_i),
    .load  (load),
    .step  (step),
    .data1 (data1_i),
    .data2 (data2_i),
    .acc   (acc),
    .last  (last)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state  <= IDLE;
      result <= '0;
    end else begin
      case (state)
        IDLE: if (start) state <= BUSY;
        BUSY: begin
          if (flush_i)   state <= IDLE;
          else if (last) state <= DONE;
        end
        DONE: begin
          state <= IDLE;
          if (!flush_i) result <= acc;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign stall_o = !rst_i && (load || (state == BUSY));
  assign done_o  = (state == DONE) && !flush_i;
  // The result register only captures at the end of DONE, so the finished
  // accumulator is forwarded during DONE itself.
  assign data_o  = (state == DONE) ? acc : result;

endmodule

// File: tb/tb_mul_sequencer.sv
// Scoreboard-based bench for mul_sequencer: expected products are queued at
// request time and popped when done_o pulses.
module tb_mul_sequencer;
  import alu_pkg::*;

  localparam int unsigned WIDTH = 32;

  logic             clk;
  logic             rst;
  logic             valid;
  logic [2:0]       alu_ctrl;
  logic             flush;
  logic [WIDTH-1:0] data1;
  logic [WIDTH-1:0] data2;
  logic             stall;
  logic             done;
  logic [WIDTH-1:0] data;

  int unsigned checks;
  int unsigned failures;
  logic [WIDTH-1:0] exp_q[$];

  mul_sequencer #(
    .WIDTH   (WIDTH),
    .CTRL_MUL(ALU_MUL)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .valid_i  (valid),
    .ALUCtrl_i(alu_ctrl),
    .flush_i  (flush),
    .data1_i  (data1),
    .data2_i  (data2),
    .stall_o  (stall),
    .done_o   (done),
    .data_o   (data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_done_data(input string name);
    logic [WIDTH-1:0] exp;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL %s: done_o pulsed with no outstanding request, data_o=%h", name, data);
    end else begin
      exp = exp_q.pop_front();
      if (data !== exp) begin
        failures++;
        $display("FAIL %s: data_o=%h expected=%h", name, data, exp);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    valid = 1'b1; alu_ctrl = ALU_MUL; flush = 1'b0;
    data1 = 32'd9; data2 = 32'd9;
    #1;
    checks++;
    if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall: stall_o=%b expected=0", stall); end
    checks++;
    if (done !== 1'b0) begin failures++; $display("FAIL reset_done: done_o=%b expected=0", done); end
    checks++;
    if (data !== '0) begin failures++; $display("FAIL reset_data: data_o=%h expected=0", data); end
    valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    next_cycle();
  endtask

  // Full single multiply with per-cycle stall/done checks; cycle 0 is the request cycle.
  task automatic run_mul(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input string name);
    logic [WIDTH-1:0] prod;
    bit seen;
    prod = a * b;
    seen = 0;
    exp_q.push_back(prod);
    for (int k = 0; k <= 35; k++) begin
      if (k == 0) begin
        valid = 1'b1; alu_ctrl = ALU_MUL; flush = 1'b0; data1 = a; data2 = b;
      end else begin
        valid = 1'b0; data1 = $urandom; data2 = $urandom;
      end
      @(negedge clk);
      checks++;
      if (stall !== (k <= 32)) begin
        failures++;
        $display("FAIL %s_stall: cycle %0d stall_o=%b expected=%b", name, k, stall, (k <= 32));
      end
      checks++;
      if (done !== (k == 33)) begin
        failures++;
        $display("FAIL %s_done: cycle %0d done_o=%b expected=%b", name, k, done, (k == 33));
      end
      if (done === 1'b1) begin
        seen = 1;
        check_done_data(name);
      end
      next_cycle();
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL %s_timeout: done_o not seen within 35 cycles, expected=%h", name, prod);
      exp_q.delete();
    end
  endtask

  task automatic test_basic();
    run_mul(32'd7, 32'd6, "mul_7x6");
  endtask

  task automatic test_wrap();
    run_mul(32'hFFFF_FFFF, 32'h0000_0002, "mul_neg1x2");
    run_mul(32'h0001_0000, 32'h0001_0000, "mul_trunc");
    checks++;
    if (data !== 32'h0) begin failures++; $display("FAIL trunc_hold: data_o=%h expected=0", data); end
  endtask

  task automatic test_flush();
    run_mul(32'd7, 32'd6, "mul_pre_flush");
    for (int k = 0; k <= 40; k++) begin
      valid = (k == 0); alu_ctrl = ALU_MUL;
      data1 = (k == 0) ? 32'd3 : $urandom;
      data2 = (k == 0) ? 32'd5 : $urandom;
      flush = (k == 10);
      @(negedge clk);
      checks++;
      if (stall !== (k <= 10)) begin
        failures++;
        $display("FAIL flush_stall: cycle %0d stall_o=%b expected=%b", k, stall, (k <= 10));
      end
      checks++;
      if (done !== 1'b0) begin
        failures++;
        $display("FAIL flush_done: cycle %0d done_o=%b expected=0", k, done);
      end
      if (k > 10) begin
        checks++;
        if (data !== 32'd42) begin
          failures++;
          $display("FAIL flush_data: cycle %0d data_o=%h expected=%h", k, data, 32'd42);
        end
      end
      next_cycle();
    end
    flush = 1'b0;
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k <= 5; k++) begin
      valid = (k == 0); alu_ctrl = ALU_MUL; flush = 1'b0;
      data1 = 32'd11; data2 = 32'd13;
      if (k < 5) next_cycle();
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (stall !== 1'b0) begin failures++; $display("FAIL midrst_stall: stall_o=%b expected=0", stall); end
    checks++;
    if (done !== 1'b0) begin failures++; $display("FAIL midrst_done: done_o=%b expected=0", done); end
    checks++;
    if (data !== '0) begin failures++; $display("FAIL midrst_data: data_o=%h expected=0", data); end
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 40; k++) begin
      next_cycle();
      valid = 1'b0; alu_ctrl = ALU_MUL;
      @(negedge clk);
      checks++;
      if (stall !== 1'b0 || done !== 1'b0 || data !== '0) begin
        failures++;
        $display("FAIL midrst_restart: cycle %0d stall_o=%b done_o=%b data_o=%h expected 0/0/0",
                 k, stall, done, data);
      end
    end
    next_cycle();
  endtask

  task automatic test_non_mul();
    logic [2:0] codes[3];
    logic       vals[3];
    codes[0] = ALU_ADD; vals[0] = 1'b1;
    codes[1] = ALU_SUB; vals[1] = 1'b1;
    codes[2] = ALU_MUL; vals[2] = 1'b0;
    for (int c = 0; c < 3; c++) begin
      for (int k = 0; k < 6; k++) begin
        valid = vals[c]; alu_ctrl = codes[c]; flush = 1'b0;
        data1 = $urandom; data2 = $urandom;
        @(negedge clk);
        checks++;
        if (stall !== 1'b0 || done !== 1'b0) begin
          failures++;
          $display("FAIL nonmul_%0d: cycle %0d stall_o=%b done_o=%b expected 0/0", c, k, stall, done);
        end
        next_cycle();
      end
    end
    // Flush with a would-be start must not launch a multiply.
    valid = 1'b1; alu_ctrl = ALU_MUL; flush = 1'b1;
    @(negedge clk);
    checks++;
    if (stall !== 1'b0) begin failures++; $display("FAIL flush_start_stall: stall_o=%b expected=0", stall); end
    next_cycle();
    valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    checks++;
    if (stall !== 1'b0) begin failures++; $display("FAIL flush_start_idle: stall_o=%b expected=0", stall); end
    next_cycle();
  endtask

  task automatic test_back_to_back();
    int unsigned dones;
    dones = 0;
    for (int k = 0; k <= 70; k++) begin
      flush = 1'b0; alu_ctrl = ALU_MUL;
      valid = (k <= 67);
      if (k == 0) begin
        data1 = 32'd2; data2 = 32'd3; exp_q.push_back(32'd6);
      end else if (k == 34) begin
        data1 = 32'd4; data2 = 32'd5; exp_q.push_back(32'd20);
      end else begin
        data1 = $urandom; data2 = $urandom;
      end
      @(negedge clk);
      checks++;
      if (stall !== (k <= 67 && k != 33 && k != 67)) begin
        failures++;
        $display("FAIL b2b_stall: cycle %0d stall_o=%b expected=%b", k, stall,
                 (k <= 67 && k != 33 && k != 67));
      end
      checks++;
      if (done !== (k == 33 || k == 67)) begin
        failures++;
        $display("FAIL b2b_done: cycle %0d done_o=%b expected=%b", k, done, (k == 33 || k == 67));
      end
      if (done === 1'b1) begin
        dones++;
        check_done_data("b2b");
      end
      next_cycle();
    end
    checks++;
    if (dones != 2) begin
      failures++;
      $display("FAIL b2b_count: done pulses=%0d expected=2", dones);
      exp_q.delete();
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_basic();
    test_wrap();
    test_flush();
    test_reset_mid();
    test_non_mul();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
